// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory controller for the MIPS data port with a
// wait-state handshake. A request is latched in IDLE, held for WAIT_STATES
// cycles, and the array access happens on the DONE edge. The access is
// range/alignment checked against BASE_ADDR and the array size.
//
// Build option: define DMEM_PARITY_EN to store one even-parity bit per byte
// lane. A read with any lane parity mismatch reports err while still
// returning the raw word.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   ce     - access request, held by the master until ready
//   we     - 1 = write, 0 = read (sampled with ce)
//   be     - byte-lane write enables (ignored on reads)
//   addr   - byte address
//   wtData - write data
//   rdData - registered read data
//   ready  - one-cycle completion pulse
//   err    - one-cycle error flag, coincident with ready
//   busy   - high from acceptance until the ready cycle
module data_mem_ctrl #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH_LOG2  = 10,
  parameter int unsigned           WAIT_STATES = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wtData,
  output logic [DATA_WIDTH-1:0]   rdData,
  output logic                    ready,
  output logic                    err,
  output logic                    busy
);

  localparam int unsigned BYTES     = DATA_WIDTH / 8;
  localparam int unsigned LANE_LOG2 = $clog2(BYTES);
  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [ADDR_WIDTH:0]   MEM_BYTES  = (ADDR_WIDTH+1)'(DEPTH * BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [BYTES-1:0]        r_be;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [ADDR_WIDTH:0]     w_off;
  logic                    w_oor;
  logic                    w_mis;
  logic                    w_bad;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic [DATA_WIDTH-1:0]   w_rword;
  logic [DATA_WIDTH-1:0]   w_mask;
  logic [DATA_WIDTH-1:0]   w_wword;
  logic                    w_wr;
  logic                    w_par_err;

  // Offset is one bit wider than the address so that addr < BASE_ADDR shows
  // up as a borrow in the top bit rather than wrapping into range.
  assign w_off   = {1'b0, r_addr} - {1'b0, BASE_ADDR};
  assign w_oor   = w_off[ADDR_WIDTH] | (w_off >= MEM_BYTES);
  assign w_mis   = |(r_addr & ALIGN_MASK);
  assign w_bad   = w_oor | w_mis;
  assign w_idx   = w_off[LANE_LOG2 +: DEPTH_LOG2];
  assign w_rword = r_mem[w_idx];
  assign w_wr    = (r_state == DONE) & r_we & ~w_bad;

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      w_mask[8*i +: 8] = {8{r_be[i]}};
    end
  end

  assign w_wword = (w_rword & ~w_mask) | (r_wdata & w_mask);

  // Array has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_idx] <= w_wword;
    end
  end

`ifdef DMEM_PARITY_EN
  logic [BYTES-1:0] r_par [DEPTH];
  logic [BYTES-1:0] w_wpar;
  logic [BYTES-1:0] w_rpar;

  always_comb begin
    w_wpar = '0;
    w_rpar = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      w_wpar[i] = ^r_wdata[8*i +: 8];
      w_rpar[i] = ^w_rword[8*i +: 8];
    end
  end

  // Only enabled lanes get fresh parity; other lanes keep their stored bit.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_par[w_idx] <= (r_par[w_idx] & ~r_be) | (w_wpar & r_be);
    end
  end

  assign w_par_err = |(r_par[w_idx] ^ w_rpar);
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      rdData  <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (r_state)
        IDLE: begin
          // ce still high during the ready cycle belongs to the request
          // that just completed, so it must not start a new one.
          if (ce && !ready) begin
            r_addr  <= addr;
            r_we    <= we;
            r_be    <= be;
            r_wdata <= wtData;
            busy    <= 1'b1;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= (WAIT_STATES > 0) ? WAIT : DONE;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          ready   <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
          if (w_bad) begin
            err    <= 1'b1;
            rdData <= '0;
          end else if (!r_we) begin
            rdData <= w_rword;
            err    <= w_par_err;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
